// File: rtl/mem_io_responder_pkg.sv
// Shared decode constants and status-byte layout for the CPU memory responder.
package mem_io_responder_pkg;

    localparam logic [1:0]  IO_SEL         = 2'b11;
    localparam logic [31:0] IO_UART_DATA   = 32'h30000;
    localparam logic [31:0] IO_STATUS_DONE = 32'h30004;

    localparam int STAT_RX_NONEMPTY = 0;
    localparam int STAT_TX_FULL     = 1;

    function automatic logic [7:0] status_byte(input logic tx_full, input logic rx_nonempty);
        logic [7:0] s;
        s = '0;
        s[STAT_TX_FULL]     = tx_full;
        s[STAT_RX_NONEMPTY] = rx_nonempty;
        return s;
    endfunction

endpackage

// File: rtl/mem_io_responder_if.sv
// Byte-wide CPU memory bus plus UART byte handshakes seen by the responder.
interface mem_io_responder_if;

    logic        rdy_in;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic [7:0]  cpu_dout;
    logic [7:0]  mem_din;
    logic        io_buffer_full;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_full;
    logic        tx_overflow;
    logic        sim_done;

    modport slave (
        input  rdy_in, mem_a, mem_wr, cpu_dout, tx_ready, rx_data, rx_valid,
        output mem_din, io_buffer_full, tx_data, tx_valid, rx_full, tx_overflow, sim_done
    );

    modport master (
        output rdy_in, mem_a, mem_wr, cpu_dout, tx_ready, rx_data, rx_valid,
        input  mem_din, io_buffer_full, tx_data, tx_valid, rx_full, tx_overflow, sim_done
    );

endinterface

// File: rtl/mem_io_responder_byte_fifo.sv
// Byte FIFO, zero-latency head (dout = oldest entry); push while full is dropped
// unless a pop happens the same cycle. Pointers carry one extra bit for full/empty.
module byte_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [7:0]             din,
    output logic [7:0]             dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [7:0] mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        do_push, do_pop;

    assign count   = wr_ptr - rd_ptr;
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (count == FULL_CNT);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/mem_io_responder.sv
// CPU memory responder: RAM plus UART window at addr[17:16]==11; reads return one cycle later.
// io_buffer_full asserts two slots early so an in-flight IO write is never lost; rdy_in low freezes the bus.
module mem_io_responder #(
    parameter int ADDR_WIDTH = 17,
    parameter int TX_DEPTH   = 8,
    parameter int RX_DEPTH   = 8
) (
    input  logic            clk_in,
    input  logic            rst_in,
    mem_io_responder_if.slave bus
);
    import mem_io_responder_pkg::*;

    localparam int TCW = $clog2(TX_DEPTH) + 1;
    localparam int RCW = $clog2(RX_DEPTH) + 1;
    localparam logic [TCW-1:0] TX_ALMOST = TCW'(TX_DEPTH - 2);

    logic [7:0] ram [2**ADDR_WIDTH];

    logic [17:0]     a18;
    logic            io, rd_data, rd_status, wr_data, wr_done, ram_wr;
    logic [7:0]      tx_dout, rx_dout;
    logic [TCW-1:0]  tx_count, tx_occ_next;
    logic [RCW-1:0]  rx_count;
    logic            tx_full, tx_empty, rx_full, rx_empty;
    logic            tx_pop, tx_push_ok, rx_pop;
    logic [7:0]      din_q;
    logic            ibf_q, ovf_q, done_q, armed_q;
    logic            unused_bits;

    assign a18       = bus.mem_a[17:0];
    assign io        = (bus.mem_a[17:16] == IO_SEL);
    assign rd_data   = bus.rdy_in && io && !bus.mem_wr && (a18 == IO_UART_DATA[17:0]);
    assign rd_status = bus.rdy_in && io && !bus.mem_wr && (a18 == IO_STATUS_DONE[17:0]);
    assign wr_data   = bus.rdy_in && io && bus.mem_wr && (a18 == IO_UART_DATA[17:0]);
    assign wr_done   = bus.rdy_in && io && bus.mem_wr && (a18 == IO_STATUS_DONE[17:0]);
    assign ram_wr    = bus.rdy_in && bus.mem_wr && !io;

    assign tx_pop      = bus.tx_ready && !tx_empty;
    assign tx_push_ok  = wr_data && (!tx_full || tx_pop);
    assign tx_occ_next = tx_count + TCW'(tx_push_ok) - TCW'(tx_pop);
    // Only the first cycle of a run of data reads consumes an RX byte.
    assign rx_pop      = rd_data && armed_q && !rx_empty;

    byte_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk(clk_in), .rst(rst_in), .push(wr_data), .pop(tx_pop), .din(bus.cpu_dout),
        .dout(tx_dout), .count(tx_count), .full(tx_full), .empty(tx_empty)
    );

    byte_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk(clk_in), .rst(rst_in), .push(bus.rx_valid && !rx_full), .pop(rx_pop), .din(bus.rx_data),
        .dout(rx_dout), .count(rx_count), .full(rx_full), .empty(rx_empty)
    );

    always_ff @(posedge clk_in) begin
        if (ram_wr) ram[bus.mem_a[ADDR_WIDTH-1:0]] <= bus.cpu_dout;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            din_q   <= 8'h00;
            ibf_q   <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
            armed_q <= 1'b1;
        end else begin
            ibf_q   <= (tx_occ_next >= TX_ALMOST);
            ovf_q   <= ovf_q | (wr_data && tx_full && !tx_pop);
            done_q  <= wr_done;
            armed_q <= !rd_data;
            // RAM path reads before the write lands, so same-address writes return the old byte.
            if (bus.rdy_in) begin
                if (!io) begin
                    din_q <= ram[bus.mem_a[ADDR_WIDTH-1:0]];
                end else if (!bus.mem_wr) begin
                    if (rd_data) begin
                        if (armed_q) din_q <= rx_empty ? 8'h00 : rx_dout;
                    end else if (rd_status) begin
                        din_q <= status_byte(tx_full, !rx_empty);
                    end else begin
                        din_q <= 8'h00;
                    end
                end
            end
        end
    end

    assign bus.mem_din        = din_q;
    assign bus.io_buffer_full = ibf_q;
    assign bus.tx_data        = tx_dout;
    assign bus.tx_valid       = !tx_empty;
    assign bus.rx_full        = rx_full;
    assign bus.tx_overflow    = ovf_q;
    assign bus.sim_done       = done_q;

    assign unused_bits = ^{bus.mem_a[31:18], rx_count};

endmodule

// File: tb/tb_mem_io_responder.sv
// Self-checking bench for mem_io_responder: RAM vector table, TX/RX FIFO sequences, reset.
module tb_mem_io_responder;
    import mem_io_responder_pkg::*;

    logic clk_in = 1'b0;
    logic rst_in = 1'b0;

    mem_io_responder_if bus ();

    mem_io_responder #(.ADDR_WIDTH(17), .TX_DEPTH(8), .RX_DEPTH(8)) dut (
        .clk_in(clk_in),
        .rst_in(rst_in),
        .bus   (bus)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        logic        rdy;
        logic        wr;
        logic [31:0] a;
        logic [7:0]  d;
        logic        chk;
        logic [7:0]  exp;
    } vec_t;

    int checks = 0;
    int passes = 0;
    logic [7:0] din_q [$];
    logic [7:0] tx_q  [$];
    vec_t vt [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic drive(input logic rdy, input logic wr, input logic [31:0] a, input logic [7:0] d);
        bus.rdy_in   = rdy;
        bus.mem_wr   = wr;
        bus.mem_a    = a;
        bus.cpu_dout = d;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 32'h0, 8'h00);
    endtask

    task automatic rd_chk(input string name, input logic [31:0] a, input logic [7:0] exp);
        drive(1'b1, 1'b0, a, 8'h00);
        din_q.push_back(exp);
        tick();
        check(name, bus.mem_din, din_q.pop_front());
    endtask

    task automatic tx_write(input logic [7:0] d, input logic accept);
        drive(1'b1, 1'b1, IO_UART_DATA, d);
        if (accept) tx_q.push_back(d);
        tick();
    endtask

    // Every TX handshake must deliver the next byte the bench queued, in order.
    always @(negedge clk_in) begin : tx_mon
        logic [31:0] e;
        if (!rst_in && bus.tx_valid && bus.tx_ready) begin
            e = (tx_q.size() > 0) ? {24'h0, tx_q.pop_front()} : 32'hDEAD_BEEF;
            check("tx_drain", {24'h0, bus.tx_data}, e);
        end
    end

    initial begin
        idle();
        bus.tx_ready = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;

        #1 rst_in = 1'b1;
        repeat (2) @(posedge clk_in);
        #1;
        check("rst_mem_din", bus.mem_din, 8'h00);
        check("rst_ibf", bus.io_buffer_full, 1'b0);
        check("rst_tx_valid", bus.tx_valid, 1'b0);
        check("rst_tx_overflow", bus.tx_overflow, 1'b0);
        check("rst_sim_done", bus.sim_done, 1'b0);
        check("rst_rx_full", bus.rx_full, 1'b0);
        rst_in = 1'b0;
        tick();

        // RAM: read latency, read-first, rdy_in gating, IO miss, aliasing of upper bits.
        vt[0]  = '{1'b1, 1'b1, 32'h0000_0123, 8'hA5, 1'b0, 8'h00};
        vt[1]  = '{1'b1, 1'b0, 32'h0000_0123, 8'h00, 1'b1, 8'hA5};
        vt[2]  = '{1'b1, 1'b1, 32'h0000_0123, 8'h5A, 1'b1, 8'hA5};
        vt[3]  = '{1'b1, 1'b1, 32'h0000_0200, 8'h77, 1'b0, 8'h00};
        vt[4]  = '{1'b1, 1'b0, 32'h0000_0123, 8'h00, 1'b1, 8'h5A};
        vt[5]  = '{1'b0, 1'b1, 32'h0000_0200, 8'h11, 1'b1, 8'h5A};
        vt[6]  = '{1'b1, 1'b0, 32'h0000_0200, 8'h00, 1'b1, 8'h77};
        vt[7]  = '{1'b1, 1'b0, 32'h0003_1000, 8'h00, 1'b1, 8'h00};
        vt[8]  = '{1'b1, 1'b0, 32'h0003_0004, 8'h00, 1'b1, 8'h00};
        vt[9]  = '{1'b1, 1'b1, 32'h0002_0123, 8'h99, 1'b1, 8'h5A};
        vt[10] = '{1'b1, 1'b0, 32'hFFFC_0123, 8'h00, 1'b1, 8'h99};
        for (int i = 0; i < 11; i++) begin
            drive(vt[i].rdy, vt[i].wr, vt[i].a, vt[i].d);
            if (vt[i].chk) din_q.push_back(vt[i].exp);
            tick();
            if (vt[i].chk) check($sformatf("ram_vec%0d", i), bus.mem_din, din_q.pop_front());
        end
        idle();

        // Single TX byte held until the UART accepts it.
        tx_write(8'h41, 1'b1);
        idle();
        check("tx1_valid", bus.tx_valid, 1'b1);
        check("tx1_data", bus.tx_data, 8'h41);
        tick(); tick();
        check("tx1_hold_valid", bus.tx_valid, 1'b1);
        check("tx1_hold_data", bus.tx_data, 8'h41);
        bus.tx_ready = 1'b1;
        tick();
        bus.tx_ready = 1'b0;
        check("tx1_done", bus.tx_valid, 1'b0);

        // Fill TX: almost-full after the 6th byte, 8th accepted, 9th dropped.
        for (int k = 1; k <= 8; k++) begin
            tx_write(8'h10 + 8'(k), 1'b1);
            check($sformatf("ibf_after_%0d", k), bus.io_buffer_full, (k >= 6));
        end
        check("ovf_at_full", bus.tx_overflow, 1'b0);
        tx_write(8'hEE, 1'b0);
        idle();
        check("ovf_dropped", bus.tx_overflow, 1'b1);
        rd_chk("status_txfull", IO_STATUS_DONE, 8'h02);

        // Push and pop in the same cycle while full: both accepted.
        bus.tx_ready = 1'b1;
        tx_write(8'h5C, 1'b1);
        idle();
        check("ibf_full_pushpop", bus.io_buffer_full, 1'b1);
        check("ovf_sticky", bus.tx_overflow, 1'b1);
        repeat (10) tick();
        bus.tx_ready = 1'b0;
        check("tx_drained_valid", bus.tx_valid, 1'b0);
        check("tx_drained_ibf", bus.io_buffer_full, 1'b0);
        check("tx_all_delivered", tx_q.size(), 0);

        // RX: one pop per read run; runs end on any non-read cycle.
        bus.rx_valid = 1'b1;
        bus.rx_data  = 8'h33;
        tick();
        bus.rx_data  = 8'h44;
        tick();
        bus.rx_valid = 1'b0;
        rd_chk("status_rx", IO_STATUS_DONE, 8'h01);
        for (int i = 0; i < 3; i++) rd_chk($sformatf("rx_run%0d", i), IO_UART_DATA, 8'h33);
        idle(); tick();
        rd_chk("rx_second", IO_UART_DATA, 8'h44);
        idle(); tick();
        rd_chk("rx_empty", IO_UART_DATA, 8'h00);

        // RX overfill: 9 pushes, ninth dropped.
        bus.rx_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            bus.rx_data = 8'h80 + 8'(i);
            tick();
        end
        bus.rx_valid = 1'b0;
        check("rx_full", bus.rx_full, 1'b1);
        for (int i = 0; i < 8; i++) begin
            idle(); tick();
            rd_chk($sformatf("rx_fill%0d", i), IO_UART_DATA, 8'h80 + 8'(i));
        end
        check("rx_not_full", bus.rx_full, 1'b0);
        idle(); tick();
        rd_chk("rx_ninth_dropped", IO_UART_DATA, 8'h00);

        // sim_done pulse.
        drive(1'b1, 1'b1, IO_STATUS_DONE, 8'hFF);
        tick();
        idle();
        check("sim_done_pulse", bus.sim_done, 1'b1);
        check("sim_done_no_tx", bus.tx_valid, 1'b0);
        tick();
        check("sim_done_clear", bus.sim_done, 1'b0);
        rd_chk("status_idle", IO_STATUS_DONE, 8'h00);

        // Async reset mid-drain; RAM survives.
        for (int k = 0; k < 8; k++) tx_write(8'hC0 + 8'(k), 1'b1);
        idle();
        bus.tx_ready = 1'b1;
        tick(); tick();
        bus.tx_ready = 1'b0;
        check("pre_rst_ibf", bus.io_buffer_full, 1'b1);
        check("pre_rst_valid", bus.tx_valid, 1'b1);
        #2 rst_in = 1'b1;
        #1;
        check("async_rst_valid", bus.tx_valid, 1'b0);
        check("async_rst_ibf", bus.io_buffer_full, 1'b0);
        check("async_rst_ovf", bus.tx_overflow, 1'b0);
        tx_q.delete();
        tick();
        rst_in = 1'b0;
        tick();
        rd_chk("ram_keep_123", 32'h0000_0123, 8'h99);
        rd_chk("ram_keep_200", 32'h0000_0200, 8'h77);
        idle();
        tick();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
